// File: rtl/mem_stall_ctrl_pkg.sv
// Shared types and constants for the MEM-stage stall controller.
package mem_ctrl_pkg;

  // Memory access sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Register $zero never creates a data dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/mem_stall_ctrl_if.sv
// Pipeline/memory signal bundle between the stall controller and its environment.
interface mem_stall_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;
  logic              id_ex_mem_read;
  logic [4:0]        id_ex_rd;
  logic [4:0]        if_id_rs;
  logic [4:0]        if_id_rt;
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] rdata;
  logic              pc_en;
  logic              if_id_en;
  logic              id_ex_en;
  logic              ex_mem_en;
  logic              id_ex_flush;
  logic              mem_wb_bubble;
  logic              mem_err;
  logic [CNT_W-1:0]  stall_cycles;

  // Controller side.
  modport master (
    input  ex_mem_read, ex_mem_write, dmem_ack, dmem_rdata,
           id_ex_mem_read, id_ex_rd, if_id_rs, if_id_rt,
    output dmem_req, dmem_we, rdata, pc_en, if_id_en, id_ex_en, ex_mem_en,
           id_ex_flush, mem_wb_bubble, mem_err, stall_cycles
  );

  // Pipeline and memory side.
  modport slave (
    output ex_mem_read, ex_mem_write, dmem_ack, dmem_rdata,
           id_ex_mem_read, id_ex_rd, if_id_rs, if_id_rt,
    input  dmem_req, dmem_we, rdata, pc_en, if_id_en, id_ex_en, ex_mem_en,
           id_ex_flush, mem_wb_bubble, mem_err, stall_cycles
  );

endinterface

// File: rtl/mem_stall_ctrl_hazard_detect.sv
// Load-use hazard detection: a load in ID/EX whose destination feeds IF/ID.
module hazard_detect
  import mem_ctrl_pkg::*;
(
  input  logic       i_id_ex_mem_read,
  input  logic [4:0] i_id_ex_rd,
  input  logic [4:0] i_if_id_rs,
  input  logic [4:0] i_if_id_rt,
  output logic       o_load_use
);

  assign o_load_use = i_id_ex_mem_read
                    & (i_id_ex_rd != REG_ZERO)
                    & ((i_id_ex_rd == i_if_id_rs) | (i_id_ex_rd == i_if_id_rt));

endmodule

// File: rtl/mem_stall_ctrl.sv
// MEM-stage controller: sequences variable-latency data memory accesses,
// freezes the front of the pipeline while one is outstanding, and resolves
// load-use hazards. Also latches load data, a sticky timeout flag and a
// saturating stall-cycle counter.
module mem_stall_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input logic              clk,
  input logic              rst,
  mem_stall_ctrl_if.master bus
);

  localparam int WCNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MAX_WAIT - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WCNT_W-1:0]   r_wait_cnt;
  logic                r_dmem_req;
  logic                r_dmem_we;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_mem_err;
  logic [CNT_W-1:0]    r_stall_cycles;

  logic w_mem_op;
  logic w_mem_stall;
  logic w_ack_take;
  logic w_timeout;
  logic w_load_use;
  logic w_lu_stall;

  assign w_mem_op = bus.ex_mem_read | bus.ex_mem_write;

  hazard_detect u_hazard_detect (
    .i_id_ex_mem_read (bus.id_ex_mem_read),
    .i_id_ex_rd       (bus.id_ex_rd),
    .i_if_id_rs       (bus.if_id_rs),
    .i_if_id_rt       (bus.if_id_rt),
    .o_load_use       (w_load_use)
  );

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and memory-stall decode.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    w_state_nxt = r_state;
    w_mem_stall = 1'b0;
    w_ack_take  = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_mem_op) begin
          w_mem_stall = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        w_mem_stall = 1'b1;
        if (bus.dmem_ack) begin
          w_ack_take  = 1'b1;
          w_state_nxt = DONE;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // Reset forces pipeline controls to their rest values.
    if (rst) begin
      w_mem_stall = 1'b0;
      w_ack_take  = 1'b0;
      w_timeout   = 1'b0;
    end
  end

  // Memory stall dominates; load-use only acts when memory is not stalling.
  assign w_lu_stall = w_load_use & ~w_mem_stall & ~rst;

  assign bus.pc_en         = ~(w_mem_stall | w_lu_stall);
  assign bus.if_id_en      = ~(w_mem_stall | w_lu_stall);
  assign bus.id_ex_en      = ~w_mem_stall;
  assign bus.ex_mem_en     = ~w_mem_stall;
  assign bus.id_ex_flush   = w_lu_stall;
  assign bus.mem_wb_bubble = w_mem_stall;

  // Request, direction, wait counter, read-data latch and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_wait_cnt <= '0;
      r_rdata    <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_dmem_req <= (w_state_nxt == WAIT);
      if (r_state == IDLE && w_mem_op) begin
        r_dmem_we  <= bus.ex_mem_write;
        r_wait_cnt <= '0;
      end
      if (w_ack_take) begin
        if (!r_dmem_we) r_rdata <= bus.dmem_rdata;
      end else if (w_timeout) begin
        r_mem_err <= 1'b1;
        r_rdata   <= '0;
      end else if (r_state == WAIT) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

  // Saturating count of cycles with any stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if ((w_mem_stall | w_load_use) && !(&r_stall_cycles)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign bus.dmem_req     = r_dmem_req;
  assign bus.dmem_we      = r_dmem_we;
  assign bus.rdata        = r_rdata;
  assign bus.mem_err      = r_mem_err;
  assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Self-checking bench for mem_stall_ctrl: directed scenarios plus randomized
// access/hazard traffic checked cycle by cycle against a transaction model.
module tb_mem_stall_ctrl;

  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 16;
  localparam int CNT_W    = 8;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;

  mem_stall_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  mem_stall_ctrl #(.DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model of registered state as seen after the most recent edge.
  bit          m_we;
  logic [31:0] m_rdata;
  bit          m_err;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit lu_rule();
    return bus.id_ex_mem_read && (bus.id_ex_rd != 5'd0) &&
           ((bus.id_ex_rd == bus.if_id_rs) || (bus.id_ex_rd == bus.if_id_rt));
  endfunction

  // 0: no hazard, 1: random registers (frequent hits, incl. $zero), 2: forced hit on rt.
  task automatic set_hz(input int mode);
    case (mode)
      0: begin
        bus.id_ex_mem_read = 1'b0;
        bus.id_ex_rd = 5'($urandom_range(0, 31));
        bus.if_id_rs = 5'($urandom_range(0, 31));
        bus.if_id_rt = 5'($urandom_range(0, 31));
      end
      1: begin
        bus.id_ex_mem_read = 1'($urandom_range(0, 1));
        bus.id_ex_rd = 5'($urandom_range(0, 3));
        bus.if_id_rs = 5'($urandom_range(0, 3));
        bus.if_id_rt = 5'($urandom_range(0, 3));
      end
      default: begin
        bus.id_ex_mem_read = 1'b1;
        bus.id_ex_rd = 5'd5;
        bus.if_id_rs = 5'd0;
        bus.if_id_rt = 5'd5;
      end
    endcase
  endtask

  // Inputs for the current cycle are already driven. Checks all outputs
  // mid-cycle, then advances the model and the clock to just after the edge.
  task automatic cycle_check(input string tag, input bit mem_stall, input bit req);
    bit lu;
    bit lu_eff;
    @(negedge clk);
    lu     = lu_rule() && !rst;
    lu_eff = lu && !mem_stall;
    check({tag, ".pc_en"},     bus.pc_en,         !(mem_stall || lu_eff));
    check({tag, ".if_id_en"},  bus.if_id_en,      !(mem_stall || lu_eff));
    check({tag, ".id_ex_en"},  bus.id_ex_en,      !mem_stall);
    check({tag, ".ex_mem_en"}, bus.ex_mem_en,     !mem_stall);
    check({tag, ".flush"},     bus.id_ex_flush,   lu_eff);
    check({tag, ".bubble"},    bus.mem_wb_bubble, mem_stall);
    check({tag, ".req"},       bus.dmem_req,      req);
    check({tag, ".we"},        bus.dmem_we,       m_we);
    check({tag, ".rdata"},     bus.rdata,         m_rdata);
    check({tag, ".err"},       bus.mem_err,       m_err);
    check({tag, ".cnt"},       bus.stall_cycles,  32'(m_cnt));
    if (rst) begin
      m_we = 0; m_rdata = '0; m_err = 0; m_cnt = 0;
    end else if ((mem_stall || lu) && m_cnt != CNT_MAX) begin
      m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input int hz_mode);
    for (int i = 0; i < n; i++) begin
      bus.ex_mem_read  = 1'b0;
      bus.ex_mem_write = 1'b0;
      bus.dmem_ack     = 1'($urandom_range(0, 1));
      bus.dmem_rdata   = $urandom;
      set_hz(hz_mode);
      cycle_check("idle", 1'b0, 1'b0);
    end
  endtask

  // One access: detection cycle, `len` WAIT cycles, one release cycle.
  // ack_at in 1..MAX_WAIT acks on that WAIT cycle; anything else times out.
  task automatic access(input bit is_store, input int ack_at,
                        input logic [31:0] data, input int hz_mode);
    bit acked = (ack_at >= 1 && ack_at <= MAX_WAIT);
    int len   = acked ? ack_at : MAX_WAIT;
    for (int c = 0; c <= len + 1; c++) begin
      if (c <= len) begin
        bus.ex_mem_read  = !is_store;
        bus.ex_mem_write = is_store;
      end else begin
        bus.ex_mem_read  = 1'($urandom_range(0, 1));
        bus.ex_mem_write = 1'b0;
      end
      if (c >= 1 && c <= len) begin
        bus.dmem_ack   = acked && (c == ack_at);
        bus.dmem_rdata = (acked && c == ack_at) ? data : $urandom;
      end else begin
        bus.dmem_ack   = 1'($urandom_range(0, 1));
        bus.dmem_rdata = $urandom;
      end
      set_hz(hz_mode);
      cycle_check(is_store ? "st" : "ld", c <= len, c >= 1 && c <= len);
      if (c == 0) m_we = is_store;
      if (c == len) begin
        if (acked) begin
          if (!is_store) m_rdata = data;
        end else begin
          m_err   = 1;
          m_rdata = '0;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.ex_mem_read = 0; bus.ex_mem_write = 0; bus.dmem_ack = 0; bus.dmem_rdata = '0;
    set_hz(0);
    m_we = 0; m_rdata = '0; m_err = 0; m_cnt = 0;
    @(posedge clk);
    #1;
    // Reset state and rest values of the controls, even with a load in EX/MEM.
    bus.ex_mem_read = 1'b1;
    set_hz(2);
    cycle_check("reset", 1'b0, 1'b0);
    rst = 1'b0;

    // Load acked on the first WAIT cycle.
    access(1'b0, 1, 32'h1234_5678, 0);
    check("load.rdata", bus.rdata, 32'h1234_5678);
    check("load.cnt", bus.stall_cycles, 32'd2);

    // Store acked on the fourth WAIT cycle; read data untouched.
    access(1'b1, 4, 32'hdead_beef, 0);
    check("store.rdata", bus.rdata, 32'h1234_5678);
    check("store.cnt", bus.stall_cycles, 32'd7);
    idle(1, 0);

    // Load-use with no memory op, then the same registers with rd=$zero.
    set_hz(2);
    bus.ex_mem_read = 0; bus.ex_mem_write = 0; bus.dmem_ack = 0;
    cycle_check("lu", 1'b0, 1'b0);
    idle(1, 0);
    set_hz(2);
    bus.id_ex_rd = 5'd0; bus.if_id_rt = 5'd0;
    cycle_check("lu_zero", 1'b0, 1'b0);

    // Load-use held across a memory access: no flush until the release cycle.
    access(1'b0, 2, 32'h0bad_cafe, 2);
    idle(1, 0);

    // Timeout, then a good access with the error flag staying set.
    access(1'b0, 0, 32'h0, 0);
    check("timeout.err", bus.mem_err, 1'b1);
    check("timeout.rdata", bus.rdata, 32'h0);
    access(1'b0, 3, 32'h5555_aaaa, 0);
    check("err_sticky", bus.mem_err, 1'b1);

    // Randomized traffic; long runs also drive the counter into saturation.
    for (int i = 0; i < 30; i++) begin
      idle($urandom_range(0, 2), 1);
      access(1'($urandom_range(0, 1)), $urandom_range(0, MAX_WAIT + 2), $urandom, 1);
    end

    // Reset on the third WAIT cycle; an ack one cycle later is ignored.
    for (int c = 0; c <= 4; c++) begin
      bus.ex_mem_read  = (c <= 3);
      bus.ex_mem_write = 1'b0;
      bus.dmem_ack     = (c == 4);
      bus.dmem_rdata   = 32'hfeed_f00d;
      set_hz(1);
      rst = (c == 3);
      if (c == 3)      cycle_check("rst_wait", 1'b0, 1'b1);
      else if (c == 4) cycle_check("rst_after", 1'b0, 1'b0);
      else             cycle_check("rst_pre", 1'b1, c >= 1);
      if (c == 0) m_we = 0;
    end
    rst = 1'b0;
    idle(2, 0);
    check("rst.rdata", bus.rdata, 32'h0);
    check("rst.err", bus.mem_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
